dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time and answers with a one-cycle ack.
// Optional wait states are enabled by defining DMEM_WAIT_STATE_EN (otherwise fixed 1-cycle response).
module dmem_responder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WAIT   = 2
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef DMEM_WAIT_STATE_EN
  localparam int unsigned EFF_WAIT = WAIT;
`else
  localparam int unsigned EFF_WAIT = 0;
`endif
  localparam logic [3:0] CNT_INIT = (EFF_WAIT == 0) ? 4'd0 : 4'(EFF_WAIT - 1);

  if (WAIT > 15) begin : g_wait_range
    $error("dmem_responder: WAIT must be in 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [DEPTH];

  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic              fault;
  logic [ADDR_W-1:0] idx;
  logic              enter_resp;
  logic              wr_en;

  // With zero wait states the access happens on the acceptance edge, so take the live inputs.
  always_comb begin
    acc_we     = lat_we;
    acc_addr   = lat_addr;
    acc_wdata  = lat_wdata;
    if (state == ST_IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
    end
    fault      = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_W + 2)) != 32'd0);
    idx        = acc_addr[ADDR_W+1:2];
    enter_resp = clear &&
                 (((state == ST_IDLE) && req && (EFF_WAIT == 0)) ||
                  ((state == ST_WAIT) && (cnt == 4'd0)));
    wr_en      = enter_resp && acc_we && !fault;
  end

  assign busy = ((state == ST_IDLE) && req) || (state == ST_WAIT);

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      ack       <= 1'b0;
      rdata     <= 32'd0;
      err       <= 1'b0;
    end else begin
      ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            if (EFF_WAIT == 0) begin
              state <= ST_RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      // Stores echo their data; faults return zero and suppress the write.
      if (enter_resp) begin
        ack <= 1'b1;
        err <= fault;
        if (fault) begin
          rdata <= 32'd0;
        end else if (acc_we) begin
          rdata <= acc_wdata;
        end else begin
          rdata <= mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus queues expected responses, a monitor checks each ack.
module tb_dmem_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WAIT_P = 2;
`ifdef DMEM_WAIT_STATE_EN
  localparam int EFF = WAIT_P;
`else
  localparam int EFF = 0;
`endif

  logic        clk;
  logic        clear;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;
  logic        err;

  typedef struct {
    logic [31:0] r;
    logic        e;
    int          c;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  dmem_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT_P)) dut (
    .clk   (clk),
    .clear (clear),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .rdata (rdata),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest queued expectation, in the expected cycle.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (ack === 1'b1) begin
        if (q.size() == 0) begin
          chk("spurious_ack", 32'(ack), 32'd0);
        end else begin
          x = q.pop_front();
          chk("rdata", rdata, x.r);
          chk("err", 32'(err), 32'(x.e));
          chk("ack_cycle", 32'(cyc), 32'(x.c));
        end
      end else if (q.size() > 0 && q[0].c < cyc) begin
        x = q.pop_front();
        chk("ack_missing", 32'(ack), 32'd1);
      end
    end
  end

  // Issue one access from an IDLE negedge; returns at the negedge of the following IDLE cycle.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic ee, input bit hold,
                        input string tag);
    exp_t x;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    #1;
    chk($sformatf("%s_busy_idle", tag), 32'(busy), 32'd1);
    x.r = er;
    x.e = ee;
    x.c = cyc + 1 + EFF;
    q.push_back(x);
    @(posedge clk);
    for (int k = 0; k < EFF; k++) begin
      @(negedge clk);
      we    = ~w;
      addr  = 32'hFFFF_FFFF;
      wdata = ~d;
      chk($sformatf("%s_busy_wait%0d", tag, k), 32'(busy), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    chk($sformatf("%s_busy_resp", tag), 32'(busy), 32'd0);
    if (!hold) begin
      req   = 1'b0;
      we    = ~w;
      addr  = 32'h0000_0003;
      wdata = ~d;
    end
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s_rdata_hold", tag), rdata, er);
    chk($sformatf("%s_err_hold", tag), 32'(err), 32'(ee));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, limit 100000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    clear = 1'b1;

    // Known contents for locations read later.
    access(1'b1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "init0");
    access(1'b1, 32'h0000_0004, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, "init4");
    access(1'b1, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "init20");

    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, "st10");
    access(1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, "ld10");
    access(1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "ld0");

    // Faults: misaligned and out of range must not write.
    access(1'b1, 32'h0000_0006, 32'hCAFE_0006, 32'h0000_0000, 1'b1, 1'b0, "st6_mis");
    access(1'b0, 32'h0000_0004, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, "ld4_after");
    access(1'b1, 32'h0000_0400, 32'hAAAA_5555, 32'h0000_0000, 1'b1, 1'b0, "st400_oor");
    access(1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "ld0_alias");
    access(1'b1, 32'h8000_0010, 32'h5555_AAAA, 32'h0000_0000, 1'b1, 1'b0, "st_hi_oor");
    access(1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, "ld10_again");

    // Back-to-back with req held through RESP.
    access(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, "st8_b2b");
    access(1'b0, 32'h0000_0008, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "ld8_b2b");

    // Top word boundary.
    access(1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b0, "st3fc");
    access(1'b0, 32'h0000_03FC, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 1'b0, "ld3fc");

    // Asynchronous reset clears held rdata without a clock edge.
    #2;
    clear = 1'b0;
    #1;
    chk("async_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    clear = 1'b1;

    access(1'b0, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, "ld3_mis");
    #2;
    clear = 1'b0;
    #1;
    chk("async_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    access(1'b0, 32'h0000_03FC, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 1'b0, "ld3fc_post_rst");

`ifdef DMEM_WAIT_STATE_EN
    // Reset during WAIT abandons the store.
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h0000_0020;
    wdata = 32'd5;
    @(posedge clk);
    @(negedge clk);
    req   = 1'b0;
    clear = 1'b0;
    #1;
    chk("abandon_ack", 32'(ack), 32'd0);
    chk("abandon_busy", 32'(busy), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    access(1'b0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, "ld20_abandon");
`endif

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
